// File: rtl/mem_stall_resp_if.sv
// mem_stall_resp_if: memory-stage request/response bundle between pipeline and data memory
// Signals: Rd, Wr, Addr (byte address), DataIn driven by the requester (master);
//          DataOut, Done, Stall, Err driven by the memory responder (slave).
interface mem_stall_resp_if;
    logic        Rd;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        Err;
    modport master (output Rd, Wr, Addr, DataIn, input DataOut, Done, Stall, Err);
    modport slave  (input Rd, Wr, Addr, DataIn, output DataOut, Done, Stall, Err);
endinterface

// File: rtl/mem_stall_resp.sv
// mem_stall_resp: multi-cycle data-memory responder that stalls the requester for LATENCY cycles
// Ports: clk (rising edge), rst (async, active-high), bus (mem_stall_resp_if.slave):
//        Rd/Wr/Addr/DataIn in, DataOut/Done/Stall/Err out.
// Parameters: ADDR_W word-address bits (2**ADDR_W x 16-bit array), LATENCY 1..15.
// Option: define MEM_STALL_RESP_HIT_EN for a one-entry last-access buffer that lets
//         a repeated read finish in the request cycle.
module mem_stall_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input logic             clk,
    input logic             rst,
    mem_stall_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [3:0] CNT0 = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              is_wr, is_wr_nx;
    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [15:0]       rdata, hit_data;
    logic              req, err, hit;
    assign idx   = bus.Addr[ADDR_W:1];
    assign rdata = mem[idx];
    assign req   = state == IDLE && (bus.Rd ^ bus.Wr) && !bus.Addr[0];
    assign err   = state == IDLE && ((bus.Rd && bus.Wr) || ((bus.Rd || bus.Wr) && bus.Addr[0]));
`ifdef MEM_STALL_RESP_HIT_EN
    logic              hit_valid;
    logic [ADDR_W-1:0] hit_tag;
    // Every completed access refreshes the buffer, so a write to the buffered word keeps it coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_tag   <= '0;
            hit_data  <= '0;
        end else if (state == DONE) begin
            hit_valid <= 1'b1;
            hit_tag   <= idx;
            hit_data  <= is_wr ? bus.DataIn : rdata;
        end
    end
    assign hit = req && bus.Rd && hit_valid && hit_tag == idx;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            is_wr <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            is_wr <= is_wr_nx;
        end
    end
    // The array has no reset; an async reset forces IDLE, so a pending write can never commit.
    always_ff @(posedge clk) begin
        if (state == DONE && is_wr) mem[idx] <= bus.DataIn;
    end
    // The operation is latched at acceptance so a requester dropping Rd/Wr mid-access still completes.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        is_wr_nx    = is_wr;
        if (req && !hit) begin
            state_nx = LATENCY == 1 ? DONE : WAIT;
            cnt_nx   = CNT0;
            is_wr_nx = bus.Wr;
        end else if (state == WAIT) begin
            state_nx = cnt == 4'd0 ? DONE : WAIT;
            cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
        end else if (state == DONE) begin
            state_nx = IDLE;
        end
        bus.Stall   = !rst && ((req && !hit) || state == WAIT);
        bus.Done    = !rst && (state == DONE || hit);
        bus.Err     = !rst && err;
        bus.DataOut = rst ? 16'h0000 : (state == DONE && !is_wr) ? rdata : hit ? hit_data : 16'h0000;
    end
endmodule
